// File: rtl/sram_responder.sv
// Cycle-accurate responder for a 16-bit asynchronous SRAM: byte-enabled halfword store,
// fixed-latency read pipeline driving the shared DQ bus, access counters and sticky errors.
module sram_responder #(
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    inout  wire  [15:0]           SRAM_DQ,
    input  logic                  SRAM_WE_N,
    input  logic                  SRAM_CE_N,
    input  logic                  SRAM_OE_N,
    input  logic                  SRAM_UB_N,
    input  logic                  SRAM_LB_N,
    input  logic                  err_clr,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic                  oob_err,
    output logic                  be_err
);

    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef struct packed {
        logic [15:0] data;
        logic        lb_n;
        logic        ub_n;
        logic        in_range;
    } stage_t;

    logic            is_wr;
    logic            is_rd;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic [15:0]     mem_q [MEM_DEPTH];

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    stage_t [READ_LATENCY-1:0] stg_q, stg_d;
    stage_t          cap;
    stage_t          last;
    logic [15:0]     out_word;
    logic            dq_oe;

    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic [15:0]     rd_cnt_q, rd_cnt_d;
    logic            oob_q, oob_d;
    logic            be_q, be_d;

    // WE_N low always classifies as a write, so read and write never coincide.
    assign is_wr    = ~SRAM_CE_N & ~SRAM_WE_N;
    assign is_rd    = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
    assign in_range = {1'b0, SRAM_ADDR} < DepthExt;
    assign idx      = SRAM_ADDR[IdxW-1:0];

    always_ff @(posedge clk) begin
        if (is_wr && in_range && !SRAM_LB_N) begin
            mem_q[idx][7:0] <= SRAM_DQ[7:0];
        end
        if (is_wr && in_range && !SRAM_UB_N) begin
            mem_q[idx][15:8] <= SRAM_DQ[15:8];
        end
    end

    always_comb begin
        cap          = '0;
        cap.data     = mem_q[idx];
        cap.lb_n     = SRAM_LB_N;
        cap.ub_n     = SRAM_UB_N;
        cap.in_range = in_range;
    end

    // Stage 0 holds the newest capture; stage READ_LATENCY-1 feeds the bus.
    if (READ_LATENCY == 1) begin : g_single
        assign vld_d = is_rd;
        assign stg_d = cap;
    end else begin : g_shift
        assign vld_d = {vld_q[READ_LATENCY-2:0], is_rd};
        assign stg_d = {stg_q[READ_LATENCY-2:0], cap};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        stg_q <= stg_d;
    end

    always_comb begin
        last     = stg_q[READ_LATENCY-1];
        out_word = 16'h0000;
        if (last.in_range) begin
            out_word[15:8] = last.ub_n ? 8'h00 : last.data[15:8];
            out_word[7:0]  = last.lb_n ? 8'h00 : last.data[7:0];
        end
    end

    // Enable is purely combinational on the pins so a falling WE_N frees the bus at once.
    assign dq_oe   = vld_q[READ_LATENCY-1] & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
    assign SRAM_DQ = dq_oe ? out_word : 16'hzzzz;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (is_wr && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (is_rd && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        // A new error in the clearing cycle wins over the clear.
        oob_d = (oob_q & ~err_clr) | ((is_wr | is_rd) & ~in_range);
        be_d  = (be_q & ~err_clr) | (is_wr & SRAM_UB_N & SRAM_LB_N);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            oob_q    <= 1'b0;
            be_q     <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            oob_q    <= oob_d;
            be_q     <= be_d;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
    assign oob_err  = oob_q;
    assign be_err   = be_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) share the control pins; each has its own
// pulled-up DQ bus so a released bus reads 16'hFFFF.
module tb_sram_responder;

    localparam int unsigned AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          we_n = 1'b1;
    logic          ce_n = 1'b1;
    logic          oe_n = 1'b1;
    logic          ub_n = 1'b1;
    logic          lb_n = 1'b1;
    logic          err_clr = 1'b0;
    logic          tb_oe = 1'b0;
    logic [15:0]   tb_dq = '0;

    tri1 [15:0]    dq_a;
    tri1 [15:0]    dq_b;
    logic [15:0]   wr_cnt_a, rd_cnt_a, wr_cnt_b, rd_cnt_b;
    logic          oob_a, be_a, oob_b, be_b;

    assign dq_a = tb_oe ? tb_dq : 16'hzzzz;
    assign dq_b = tb_oe ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_WIDTH(AW), .MEM_DEPTH(1024), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq_a), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
        .err_clr(err_clr), .wr_count(wr_cnt_a), .rd_count(rd_cnt_a), .oob_err(oob_a),
        .be_err(be_a)
    );

    sram_responder #(.ADDR_WIDTH(AW), .MEM_DEPTH(1024), .READ_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq_b), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
        .err_clr(err_clr), .wr_count(wr_cnt_b), .rd_count(rd_cnt_b), .oob_err(oob_b),
        .be_err(be_b)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    // A due read is seen only if the pins enable output that cycle; otherwise the bus must
    // show just what the bench drives (or the pull-up).
    task automatic lane_check(input int k, input logic [15:0] pin, input string nm);
        exp_t        e;
        bit          hit;
        bit          en;
        logic [15:0] want;
        hit = 1'b0;
        e   = '{0, 16'h0000};
        if (k == 0) begin
            if (q_a.size() > 0 && q_a[0].due <= cyc) begin
                e   = q_a.pop_front();
                hit = 1'b1;
            end
        end else begin
            if (q_b.size() > 0 && q_b[0].due <= cyc) begin
                e   = q_b.pop_front();
                hit = 1'b1;
            end
        end
        if (hit && e.due != cyc) begin
            failures++;
            $display("FAIL %s_stale cyc=%0d due=%0d", nm, cyc, e.due);
        end
        en   = rst && !ce_n && !oe_n && we_n;
        want = (hit && en && e.due == cyc) ? e.val : (tb_oe ? tb_dq : 16'hFFFF);
        check(nm, pin, want);
    endtask

    always @(negedge clk) begin
        lane_check(0, dq_a, "dq_lat1");
        lane_check(1, dq_b, "dq_lat3");
    end

    task automatic drive(input logic c, input logic w, input logic o, input logic u,
                         input logic l, input logic [AW-1:0] a, input logic [15:0] d,
                         input logic [15:0] exp, input logic clr);
        ce_n    = c;
        we_n    = w;
        oe_n    = o;
        ub_n    = u;
        lb_n    = l;
        addr    = a;
        tb_dq   = d;
        tb_oe   = !c && !w;
        err_clr = clr;
        if (rst && !c && w && !o) begin
            q_a.push_back('{cyc + 1, exp});
            q_b.push_back('{cyc + 3, exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic u,
                      input logic l);
        drive(1'b0, 1'b0, 1'b1, u, l, a, d, 16'h0000, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic u, input logic l,
                      input logic [15:0] exp);
        drive(1'b0, 1'b1, 1'b0, u, l, a, 16'h0000, exp, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000, 16'h0000, 1'b0);
        end
    endtask

    task automatic clr_pulse();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic status(input string nm, input logic [15:0] w, input logic [15:0] r,
                          input logic oob, input logic be);
        check({nm, "_wr_lat1"}, wr_cnt_a, w);
        check({nm, "_rd_lat1"}, rd_cnt_a, r);
        check({nm, "_oob_lat1"}, {15'd0, oob_a}, {15'd0, oob});
        check({nm, "_be_lat1"}, {15'd0, be_a}, {15'd0, be});
        check({nm, "_wr_lat3"}, wr_cnt_b, w);
        check({nm, "_rd_lat3"}, rd_cnt_b, r);
        check({nm, "_oob_lat3"}, {15'd0, oob_b}, {15'd0, oob});
        check({nm, "_be_lat3"}, {15'd0, be_b}, {15'd0, be});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with a read pattern on the pins: bus stays released.
        #1;
        rst  = 1'b0;
        ce_n = 1'b0;
        oe_n = 1'b0;
        we_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        status("reset", 16'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rd(18'd1024, 1'b0, 1'b0, 16'h0000);
        idle(4);
        status("release", 16'd0, 16'd4, 1'b1, 1'b0);
        clr_pulse();
        status("oob_clr0", 16'd0, 16'd4, 1'b0, 1'b0);

        // Basic write then read.
        wr(18'd5, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(18'd5, 1'b0, 1'b0, 16'h1234);
        idle(3);
        status("wr_rd", 16'd1, 16'd8, 1'b0, 1'b0);

        // Byte enables on write and read.
        wr(18'd5, 16'hABCD, 1'b1, 1'b0);
        wr(18'd5, 16'hFFFF, 1'b1, 1'b1);
        rd(18'd5, 1'b0, 1'b0, 16'h12CD);
        rd(18'd5, 1'b1, 1'b0, 16'h00CD);
        rd(18'd5, 1'b0, 1'b1, 16'h1200);
        rd(18'd5, 1'b0, 1'b0, 16'h12CD);
        idle(3);
        status("byte_en", 16'd3, 16'd12, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'd5, 16'h5555, 16'h0000, 1'b1);
        status("clr_vs_err", 16'd4, 16'd12, 1'b0, 1'b1);
        clr_pulse();
        status("be_clr", 16'd4, 16'd12, 1'b0, 1'b0);

        // 32-bit word 0x12345678 at byte address 0x10.
        wr(18'd8, 16'h5678, 1'b0, 1'b0);
        wr(18'd9, 16'h1234, 1'b0, 1'b0);
        idle(1);
        rd(18'd8, 1'b0, 1'b0, 16'h5678);
        rd(18'd9, 1'b0, 1'b0, 16'h1234);
        rd(18'd8, 1'b0, 1'b0, 16'h5678);
        rd(18'd9, 1'b0, 1'b0, 16'h1234);
        idle(3);
        status("ctrl_seq", 16'd6, 16'd16, 1'b0, 1'b0);

        // Out-of-range write must not alias onto index 0.
        wr(18'd0, 16'h0A0A, 1'b0, 1'b0);
        wr(18'd1024, 16'hFFFF, 1'b0, 1'b0);
        status("oob_wr", 16'd8, 16'd16, 1'b1, 1'b0);
        rd(18'd0, 1'b0, 1'b0, 16'h0A0A);
        rd(18'd1024, 1'b0, 1'b0, 16'h0000);
        rd(18'd0, 1'b0, 1'b0, 16'h0A0A);
        rd(18'd1024, 1'b0, 1'b0, 16'h0000);
        idle(3);
        status("oob_rd", 16'd8, 16'd20, 1'b1, 1'b0);
        clr_pulse();
        status("oob_clr", 16'd8, 16'd20, 1'b0, 1'b0);

        // Pipelined back-to-back reads.
        wr(18'd1, 16'h0011, 1'b0, 1'b0);
        wr(18'd2, 16'h0022, 1'b0, 1'b0);
        wr(18'd3, 16'h0033, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            rd(18'd1, 1'b0, 1'b0, 16'h0011);
            rd(18'd2, 1'b0, 1'b0, 16'h0022);
            rd(18'd3, 1'b0, 1'b0, 16'h0033);
        end
        idle(3);

        // Write in the cycle 0022 is due on the latency-3 lane: that word is lost.
        rd(18'd1, 1'b0, 1'b0, 16'h0011);
        rd(18'd2, 1'b0, 1'b0, 16'h0022);
        rd(18'd3, 1'b0, 1'b0, 16'h0033);
        rd(18'd1, 1'b0, 1'b0, 16'h0011);
        wr(18'd7, 16'h0777, 1'b0, 1'b0);
        rd(18'd2, 1'b0, 1'b0, 16'h0022);
        idle(4);
        status("supp", 16'd12, 16'd31, 1'b0, 1'b0);

        // Reset mid-flight drops every pending read.
        rd(18'd1, 1'b0, 1'b0, 16'h0011);
        rd(18'd2, 1'b0, 1'b0, 16'h0022);
        rd(18'd3, 1'b0, 1'b0, 16'h0033);
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rd(18'd1, 1'b0, 1'b0, 16'h0011);
        idle(4);
        status("post_reset", 16'd0, 16'd4, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
